// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges stall requests into one hold_flag level,
// forwards jumps, stretches the post-jump flush and watches for runaway bus stalls.
module pipe_hold_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int HOLD_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_ex_i,
  input  logic        hold_bus_i,
  input  logic        hold_clint_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic        flush_o,
  output logic        bus_timeout_o
);

  // Hold_Flag_Bus encoding shared with pc_reg / if_id / id_ex
  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(HOLD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_BUS_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] fcnt, fcnt_nxt;
  logic [CNT_W-1:0] scnt, scnt_nxt;

  logic [2:0] req_level;
  logic [2:0] flush_level;
  logic       timeout_hit;

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (rst_i) begin
      state <= ST_RUN;
      fcnt  <= '0;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      scnt  <= scnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first; a branch that left
    // one unassigned would infer a latch.
    state_nxt = state;
    fcnt_nxt  = fcnt;
    scnt_nxt  = scnt;

    if (jump_i && (FLUSH_CYCLES > 0)) begin
      // A jump always wins and restarts both the flush and the stall count
      state_nxt = ST_FLUSH;
      fcnt_nxt  = FLUSH_LOAD;
      scnt_nxt  = '0;
    end else begin
      case (state)
        ST_FLUSH: begin
          if (fcnt == CNT_ONE) begin
            fcnt_nxt = '0;
            if (hold_bus_i) begin
              state_nxt = ST_BUS_WAIT;
              scnt_nxt  = CNT_ONE;
            end else begin
              state_nxt = ST_RUN;
            end
          end else begin
            fcnt_nxt = fcnt - CNT_ONE;
          end
        end
        ST_RUN: begin
          if (hold_bus_i) begin
            state_nxt = ST_BUS_WAIT;
            scnt_nxt  = CNT_ONE;
          end
        end
        ST_BUS_WAIT: begin
          if (hold_bus_i) begin
            if (scnt != TIMEOUT_VAL) scnt_nxt = scnt + CNT_ONE;
          end else begin
            state_nxt = ST_RUN;
            scnt_nxt  = '0;
          end
        end
        default: begin
          state_nxt = ST_RUN;
          fcnt_nxt  = '0;
          scnt_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    if (jump_i || hold_ex_i || hold_clint_i) req_level = HOLD_ID;
    else if (hold_bus_i)                     req_level = HOLD_PC;
    else                                     req_level = HOLD_NONE;
  end

  assign flush_level = (state == ST_FLUSH) ? HOLD_ID : HOLD_NONE;

  // Pulse only on the edge into saturation, so a stall that stays high fires once
  assign timeout_hit = (scnt_nxt == TIMEOUT_VAL) && (scnt != TIMEOUT_VAL);

  assign hold_flag_o   = rst_i ? HOLD_NONE :
                         ((req_level > flush_level) ? req_level : flush_level);
  assign jump_o        = !rst_i && jump_i;
  assign jump_addr_o   = rst_i ? '0 : jump_addr_i;
  assign flush_o       = !rst_i && (jump_i || (state == ST_FLUSH));
  assign bus_timeout_o = !rst_i && timeout_hit;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl: expected outputs are queued as each step is
// driven and popped/compared mid-cycle against one of two differently sized instances.
module tb_pipe_hold_ctrl;

  localparam logic [2:0] H_NONE = 3'b000;
  localparam logic [2:0] H_PC   = 3'b001;
  localparam logic [2:0] H_ID   = 3'b011;

  typedef enum logic {SEL_A, SEL_B} sel_t;

  typedef struct packed {
    logic [2:0]  hold;
    logic        jump;
    logic [31:0] addr;
    logic        flush;
    logic        tmo;
    sel_t        sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_ex_i = 1'b0;
  logic        hold_bus_i = 1'b0;
  logic        hold_clint_i = 1'b0;

  logic [2:0]  a_hold, b_hold;
  logic        a_jump, b_jump;
  logic [31:0] a_addr, b_addr;
  logic        a_flush, b_flush;
  logic        a_tmo, b_tmo;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.FLUSH_CYCLES(1), .HOLD_TIMEOUT(255), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i), .hold_clint_i(hold_clint_i),
    .hold_flag_o(a_hold), .jump_o(a_jump), .jump_addr_o(a_addr),
    .flush_o(a_flush), .bus_timeout_o(a_tmo)
  );

  pipe_hold_ctrl #(.FLUSH_CYCLES(2), .HOLD_TIMEOUT(4), .CNT_W(8)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i), .hold_clint_i(hold_clint_i),
    .hold_flag_o(b_hold), .jump_o(b_jump), .jump_addr_o(b_addr),
    .flush_o(b_flush), .bus_timeout_o(b_tmo)
  );

  function automatic exp_t mk(input logic [2:0] hold, input logic jump,
                              input logic [31:0] addr, input logic flush,
                              input logic tmo, input sel_t sel);
    mk = '{hold: hold, jump: jump, addr: addr, flush: flush, tmo: tmo, sel: sel};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, queue the expectation, compare mid-cycle
  task automatic step(input logic r, input logic j, input logic [31:0] a,
                      input logic ex, input logic bus, input logic cl, input exp_t e);
    exp_t got;
    @(posedge clk);
    #1;
    rst_i = r; jump_i = j; jump_addr_i = a;
    hold_ex_i = ex; hold_bus_i = bus; hold_clint_i = cl;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    if (got.sel == SEL_A) begin
      check("a.hold_flag", 32'(a_hold), 32'(got.hold));
      check("a.jump",      32'(a_jump), 32'(got.jump));
      check("a.jump_addr", a_addr,      got.addr);
      check("a.flush",     32'(a_flush), 32'(got.flush));
      check("a.timeout",   32'(a_tmo),  32'(got.tmo));
    end else begin
      check("b.hold_flag", 32'(b_hold), 32'(got.hold));
      check("b.jump",      32'(b_jump), 32'(got.jump));
      check("b.jump_addr", b_addr,      got.addr);
      check("b.flush",     32'(b_flush), 32'(got.flush));
      check("b.timeout",   32'(b_tmo),  32'(got.tmo));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with every input asserted: all outputs forced low on both instances
    step(1, 1, 32'hFFFF_FFFF, 1, 1, 1, mk(H_NONE, 0, 0, 0, 0, SEL_A));
    step(1, 1, 32'hFFFF_FFFF, 1, 1, 1, mk(H_NONE, 0, 0, 0, 0, SEL_B));
    step(0, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_A));

    // Single jump, one extra flush cycle
    step(0, 1, 32'h0000_0100, 0, 0, 0, mk(H_ID, 1, 32'h100, 1, 0, SEL_A));
    step(0, 0, 0, 0, 0, 0, mk(H_ID, 0, 0, 1, 0, SEL_A));
    step(0, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_A));

    // Long bus stall: Hold_Pc throughout, one timeout pulse in stall cycle 255
    for (int k = 1; k <= 300; k++)
      step(0, 0, 0, 0, 1, 0, mk(H_PC, 0, 0, 0, (k == 255), SEL_A));
    step(0, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_A));

    // Jump in stall cycle 10: two Hold_Id cycles, stall count restarts after the flush
    for (int k = 1; k <= 270; k++) begin
      if (k == 10)
        step(0, 1, 32'h0000_2000, 0, 1, 0, mk(H_ID, 1, 32'h2000, 1, 0, SEL_A));
      else if (k == 11)
        step(0, 0, 0, 0, 1, 0, mk(H_ID, 0, 0, 1, 0, SEL_A));
      else
        step(0, 0, 0, 0, 1, 0, mk(H_PC, 0, 0, 0, (k == 265), SEL_A));
    end
    step(0, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_A));

    // ex stall dominates bus stall; dropping it falls back to Hold_Pc at once
    step(0, 0, 0, 1, 1, 0, mk(H_ID, 0, 0, 0, 0, SEL_A));
    step(0, 0, 0, 0, 1, 0, mk(H_PC, 0, 0, 0, 0, SEL_A));
    step(0, 0, 0, 0, 0, 1, mk(H_ID, 0, 0, 0, 0, SEL_A));
    step(0, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_A));

    // Reset mid-flush: the flush does not survive
    step(0, 1, 32'h0000_0300, 0, 0, 0, mk(H_ID, 1, 32'h300, 1, 0, SEL_A));
    step(1, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_A));
    step(0, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_A));

    // Watchdog on the short-timeout instance: single pulse, re-arms after drop
    for (int k = 1; k <= 6; k++)
      step(0, 0, 0, 0, 1, 0, mk(H_PC, 0, 0, 0, (k == 4), SEL_B));
    step(0, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_B));
    for (int k = 1; k <= 4; k++)
      step(0, 0, 0, 0, 1, 0, mk(H_PC, 0, 0, 0, (k == 4), SEL_B));
    step(0, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_B));

    // Reset mid-stall: no stale pulse, full recount afterwards
    for (int k = 1; k <= 3; k++)
      step(0, 0, 0, 0, 1, 0, mk(H_PC, 0, 0, 0, 0, SEL_B));
    step(1, 0, 0, 0, 1, 0, mk(H_NONE, 0, 0, 0, 0, SEL_B));
    for (int k = 1; k <= 5; k++)
      step(0, 0, 0, 0, 1, 0, mk(H_PC, 0, 0, 0, (k == 4), SEL_B));
    step(0, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_B));

    // Back-to-back jumps with two extra flush cycles: flush high for 3+2 cycles
    step(0, 1, 32'h0000_0040, 0, 0, 0, mk(H_ID, 1, 32'h40, 1, 0, SEL_B));
    step(0, 1, 32'h0000_0044, 0, 0, 0, mk(H_ID, 1, 32'h44, 1, 0, SEL_B));
    step(0, 1, 32'h0000_0048, 0, 0, 0, mk(H_ID, 1, 32'h48, 1, 0, SEL_B));
    step(0, 0, 0, 0, 0, 0, mk(H_ID, 0, 0, 1, 0, SEL_B));
    step(0, 0, 0, 0, 0, 0, mk(H_ID, 0, 0, 1, 0, SEL_B));
    step(0, 0, 0, 0, 0, 0, mk(H_NONE, 0, 0, 0, 0, SEL_B));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
